logic_sampler: RTL and testbench
================================

Name: logic_sampler

Overview:
- Capture stage directly downstream of the clock divider in the logic sniffer.
- Consumes the divider's output clock as a level in the same clock domain and derives a one-cycle sample strobe from its rising edges.
- On each strobe, samples the probe channels and evaluates a mask/value trigger; after the trigger it streams a fixed number of samples to the capture RAM write port.

Parameters:
CH, 8, number of probe channels (sample width)
AW, 10, capture RAM address width; DEPTH = 2**AW

Ports:
clk_i  input  1  system clock
rst  input  1  synchronous reset, active-high
smp_clk_i  input  1  divided clock from the divider; sampled as data in the clk_i domain
ch_i  input  CH  probe channels
arm_i  input  1  one-cycle pulse that starts an acquisition
abort_i  input  1  one-cycle pulse that cancels an acquisition
trig_mask_i  input  CH  trigger mask; 1 = channel participates
trig_val_i  input  CH  trigger compare value
n_samples_i  input  AW+1  samples to capture, trigger sample included
wr_en_o  output  1  capture RAM write strobe
wr_addr_o  output  AW  capture RAM write address
wr_data_o  output  CH  capture RAM write data
busy_o  output  1  high in ARMED or CAPTURE
triggered_o  output  1  trigger has fired in this acquisition
done_o  output  1  high in DONE

Behaviour:
- Interface: one clock, clk_i; reset rst is synchronous and active-high.
- Reset values: state IDLE; all outputs 0; smp_q 0; sample counter 0.
- Strobe generation:
  - smp_q <= smp_clk_i every cycle.
  - strobe = smp_clk_i & ~smp_q, so one strobe per 0->1 transition.
  - A level held high produces no further strobes.
- Length latch:
  - n_samples_i is latched on arm_i.
  - 0, or any value above DEPTH, is treated as DEPTH.
- States:
  - IDLE: arm_i -> ARMED; clear triggered_o and the address counter.
  - ARMED: on strobe, match = ((ch_i ^ trig_val_i) & trig_mask_i) == 0.
    - If match: set triggered_o, write the sample at address 0.
    - If length == 1 -> DONE, else -> CAPTURE with count = 1.
    - No match: stay in ARMED; nothing is written.
    - trig_mask_i = 0 triggers on the first strobe.
  - CAPTURE: on strobe, write the sample at address = count, then count++.
    - When the incremented count equals the length -> DONE.
  - DONE: hold done_o and triggered_o; arm_i re-arms (-> ARMED, clears triggered_o and the counter).
- abort_i:
  - From any state -> IDLE on the next cycle.
  - Takes priority over arm_i and strobe in the same cycle.
  - Suppresses the pending write; triggered_o clears.
- arm_i while in ARMED or CAPTURE is ignored.
- Write timing:
  - wr_en_o, wr_addr_o and wr_data_o are registered and appear exactly one clk_i cycle after the strobe cycle.
  - wr_en_o is high for 1 cycle.
  - wr_data_o equals ch_i in the strobe cycle (sync path excluded).
  - wr_addr_o holds its last value while wr_en_o is low.
- State outputs: done_o and busy_o are registered and valid in the cycle after the state change.
- Address wrap: never occurs, since the length is at most DEPTH. The last address written is length-1.
- Reset mid-capture: returns to IDLE at the next edge with outputs 0; no further writes.

Optional Feature:
- Macro: LOGIC_SAMPLER_SYNC_EN.
- When defined:
  - ch_i and smp_clk_i pass through a two-flop synchronizer before use; both are delayed equally, so sample/strobe alignment is preserved.
  - Strobe-to-write latency as seen from the pins increases by 2 cycles.
  - Synchronizer flops reset to 0.
- When undefined: inputs are used directly, and latency is as stated in Behaviour.

Decomposition:
- Package logic_sampler_pkg:
  - state enum (IDLE, ARMED, CAPTURE, DONE) with 2-bit encoding.
  - defaults for CH and AW.
- One natural sub-module: sampler_edge_det, containing the optional synchronizer, smp_q and strobe generation.
- The FSM, counter and write port stay in the top module.

Test Plan:
1. smp_clk_i period 8 cycles, mask 0x00, n_samples 4, arm -> four writes, addr 0..3, each 1 cycle after its strobe; then done_o=1 and busy_o=0.
2. mask 0x81, val 0x80, ch_i steps 0x00, 0x01, 0x80 on successive strobes -> first write occurs at the 0x80 strobe at addr 0; triggered_o rises with that write.
3. n_samples 0 with AW=4 -> exactly 16 writes, addr 0..15, then DONE; no address wrap.
4. abort_i asserted on the same cycle as a CAPTURE strobe after 2 writes -> no third write; next cycle IDLE with triggered_o=0 and done_o=0.
5. rst asserted mid-CAPTURE -> all outputs 0 next cycle; later arm_i plus one strobe with n_samples 1 -> single write at addr 0, then done_o=1.
6. smp_clk_i held high for 50 cycles -> exactly one strobe and one write. With LOGIC_SAMPLER_SYNC_EN defined, the same test shows the write 3 cycles after the pin edge.

Source files
------------

// File: rtl/logic_sampler_pkg.sv
// ============================================================================
//  Module   : logic_sampler_pkg
//  Brief    : Shared state encoding and default sizes for the logic sampler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_sampler_pkg;

    localparam int c_CH_DEFAULT = 8;
    localparam int c_AW_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sampler_edge_det.sv
// ============================================================================
//  Module   : sampler_edge_det
//  Brief    : Rising-edge strobe from the divided clock level, with the
//             optional input synchronizer (LOGIC_SAMPLER_SYNC_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sampler_edge_det
    import logic_sampler_pkg::*;
#(
    parameter int CH = c_CH_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst,
    input  logic          smp_clk_i,
    input  logic [CH-1:0] ch_i,
    output logic          strobe_o,
    output logic [CH-1:0] ch_o
);

    logic          w_smp;
    logic [CH-1:0] w_ch;
    logic          r_smp_q;

`ifdef LOGIC_SAMPLER_SYNC_EN
    // Channels ride the same two stages as the clock so each strobe still
    // lines up with the sample that was on the pins at its edge.
    logic [1:0]    r_smp_sync;
    logic [CH-1:0] r_ch_s1;
    logic [CH-1:0] r_ch_s2;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_smp_sync <= '0;
            r_ch_s1    <= '0;
            r_ch_s2    <= '0;
        end else begin
            r_smp_sync <= {r_smp_sync[0], smp_clk_i};
            r_ch_s1    <= ch_i;
            r_ch_s2    <= r_ch_s1;
        end
    end

    assign w_smp = r_smp_sync[1];
    assign w_ch  = r_ch_s2;
`else
    assign w_smp = smp_clk_i;
    assign w_ch  = ch_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_smp_q <= 1'b0;
        end else begin
            r_smp_q <= w_smp;
        end
    end

    assign strobe_o = w_smp & ~r_smp_q;
    assign ch_o     = w_ch;

endmodule

`default_nettype wire

// File: rtl/logic_sampler.sv
// ============================================================================
//  Module   : logic_sampler
//  Brief    : Mask/value triggered capture stage feeding the capture RAM.
//             Optional input synchronizer: define LOGIC_SAMPLER_SYNC_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_sampler
    import logic_sampler_pkg::*;
#(
    parameter int CH = c_CH_DEFAULT,
    parameter int AW = c_AW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst,
    input  logic          smp_clk_i,
    input  logic [CH-1:0] ch_i,
    input  logic          arm_i,
    input  logic          abort_i,
    input  logic [CH-1:0] trig_mask_i,
    input  logic [CH-1:0] trig_val_i,
    input  logic [AW:0]   n_samples_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [CH-1:0] wr_data_o,
    output logic          busy_o,
    output logic          triggered_o,
    output logic          done_o
);

    localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] c_ONE   = {{AW{1'b0}}, 1'b1};

    logic          w_strobe;
    logic [CH-1:0] w_ch;
    logic          w_match;
    logic [AW:0]   w_len_in;
    logic [AW:0]   w_cnt_nxt;

    state_t        r_state;
    logic [AW:0]   r_len;
    logic [AW:0]   r_cnt;

    sampler_edge_det #(
        .CH (CH)
    ) u_edge_det (
        .clk_i     (clk_i),
        .rst       (rst),
        .smp_clk_i (smp_clk_i),
        .ch_i      (ch_i),
        .strobe_o  (w_strobe),
        .ch_o      (w_ch)
    );

    assign w_match   = ((w_ch ^ trig_val_i) & trig_mask_i) == '0;
    // A zero or oversize request fills the whole RAM, so addresses never wrap.
    assign w_len_in  = ((n_samples_i == '0) || (n_samples_i > c_DEPTH)) ? c_DEPTH : n_samples_i;
    assign w_cnt_nxt = r_cnt + c_ONE;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            busy_o      <= 1'b0;
            triggered_o <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            wr_en_o <= 1'b0;
            if (abort_i) begin
                r_state     <= IDLE;
                busy_o      <= 1'b0;
                done_o      <= 1'b0;
                triggered_o <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (arm_i) begin
                            r_state     <= ARMED;
                            r_len       <= w_len_in;
                            r_cnt       <= '0;
                            triggered_o <= 1'b0;
                            busy_o      <= 1'b1;
                            done_o      <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (w_strobe && w_match) begin
                            triggered_o <= 1'b1;
                            wr_en_o     <= 1'b1;
                            wr_addr_o   <= '0;
                            wr_data_o   <= w_ch;
                            if (r_len == c_ONE) begin
                                r_state <= DONE;
                                busy_o  <= 1'b0;
                                done_o  <= 1'b1;
                            end else begin
                                r_state <= CAPTURE;
                                r_cnt   <= c_ONE;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (w_strobe) begin
                            wr_en_o   <= 1'b1;
                            wr_addr_o <= r_cnt[AW-1:0];
                            wr_data_o <= w_ch;
                            r_cnt     <= w_cnt_nxt;
                            if (w_cnt_nxt == r_len) begin
                                r_state <= DONE;
                                busy_o  <= 1'b0;
                                done_o  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_logic_sampler.sv
// ============================================================================
//  Module   : tb_logic_sampler
//  Brief    : Scoreboard bench for logic_sampler (CH=8, AW=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_sampler;

    localparam int CH = 8;
    localparam int AW = 4;
`ifdef LOGIC_SAMPLER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [CH-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst = 1'b1;
    logic          smp_clk_i = 1'b0;
    logic [CH-1:0] ch_i = '0;
    logic          arm_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [CH-1:0] trig_mask_i = '0;
    logic [CH-1:0] trig_val_i = '0;
    logic [AW:0]   n_samples_i = '0;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [CH-1:0] wr_data_o;
    logic          busy_o;
    logic          triggered_o;
    logic          done_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t m;

    logic_sampler #(
        .CH (CH),
        .AW (AW)
    ) dut (
        .clk_i       (clk_i),
        .rst         (rst),
        .smp_clk_i   (smp_clk_i),
        .ch_i        (ch_i),
        .arm_i       (arm_i),
        .abort_i     (abort_i),
        .trig_mask_i (trig_mask_i),
        .trig_val_i  (trig_val_i),
        .n_samples_i (n_samples_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .busy_o      (busy_o),
        .triggered_o (triggered_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Every write must match the oldest expected entry, including its cycle.
    always @(posedge clk_i) begin
        #1;
        if (wr_en_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0d data=%h cyc=%0d, want none", wr_addr_o, wr_data_o, cyc);
            end else begin
                m = sb.pop_front();
                if (wr_addr_o !== m.addr || wr_data_o !== m.data || cyc != m.cyc) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                             wr_addr_o, wr_data_o, cyc, m.addr, m.data, m.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic arm(input logic [AW:0] n);
        n_samples_i = n;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic smp_period(input logic [CH-1:0] ch, input int hi, input int lo,
                              input bit exp_wr, input int addr);
        exp_t e;
        smp_clk_i = 1'b1;
        ch_i = ch;
        if (exp_wr) begin
            e.addr = addr[AW-1:0];
            e.data = ch;
            e.cyc  = cyc + LAT;
            sb.push_back(e);
        end
        repeat (hi) tick();
        smp_clk_i = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({wr_en_o, wr_addr_o, wr_data_o, busy_o, triggered_o, done_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b addr=%0d data=%h busy=%b trig=%b done=%b, want all 0",
                     wr_en_o, wr_addr_o, wr_data_o, busy_o, triggered_o, done_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        trig_mask_i = 8'h00;
        trig_val_i  = 8'h00;
        arm(5'd4);
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_armed got busy=%b done=%b, want busy=1 done=0", busy_o, done_o);
        end
        for (int i = 0; i < 4; i++) smp_period(8'h10 + 8'(i), 4, 4, 1'b1, i);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || triggered_o !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL basic_done got done=%b busy=%b trig=%b pending=%0d, want done=1 busy=0 trig=1 pending=0",
                     done_o, busy_o, triggered_o, sb.size());
        end
    endtask

    task automatic test_trigger();
        trig_mask_i = 8'h81;
        trig_val_i  = 8'h80;
        arm(5'd2);
        checks++;
        if (triggered_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL trig_rearm got trig=%b done=%b, want trig=0 done=0", triggered_o, done_o);
        end
        smp_period(8'h00, 4, 4, 1'b0, 0);
        smp_period(8'h01, 4, 4, 1'b0, 0);
        smp_clk_i = 1'b1;
        ch_i = 8'h80;
        m.addr = '0;
        m.data = 8'h80;
        m.cyc  = cyc + LAT;
        sb.push_back(m);
        repeat (LAT - 1) tick();
        checks++;
        if (triggered_o !== 1'b0) begin
            errors++;
            $display("FAIL trig_early got trig=%b, want 0", triggered_o);
        end
        tick();
        checks++;
        if (triggered_o !== 1'b1 || wr_en_o !== 1'b1) begin
            errors++;
            $display("FAIL trig_with_write got trig=%b en=%b, want trig=1 en=1", triggered_o, wr_en_o);
        end
        repeat (4 - LAT) tick();
        smp_clk_i = 1'b0;
        repeat (4) tick();
        smp_period(8'h55, 4, 4, 1'b1, 1);
        checks++;
        if (done_o !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL trig_done got done=%b pending=%0d, want done=1 pending=0", done_o, sb.size());
        end
    endtask

    task automatic test_full_depth();
        trig_mask_i = 8'h00;
        arm(5'd0);
        for (int i = 0; i < 16; i++) smp_period(8'($urandom_range(255)), 2, 2, 1'b1, i);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL depth_done got done=%b busy=%b pending=%0d, want done=1 busy=0 pending=0",
                     done_o, busy_o, sb.size());
        end
        smp_period(8'hEE, 2, 2, 1'b0, 0);
    endtask

    task automatic test_abort();
        trig_mask_i = 8'h00;
        arm(5'd8);
        smp_period(8'h21, 4, 4, 1'b1, 0);
        smp_period(8'h22, 4, 4, 1'b1, 1);
        smp_clk_i = 1'b1;
        ch_i = 8'h23;
        repeat (LAT - 1) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || triggered_o !== 1'b0 || wr_en_o !== 1'b0) begin
            errors++;
            $display("FAIL abort got busy=%b done=%b trig=%b en=%b, want all 0",
                     busy_o, done_o, triggered_o, wr_en_o);
        end
        repeat (3) tick();
        smp_clk_i = 1'b0;
        repeat (4) tick();
        smp_period(8'h24, 4, 4, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        trig_mask_i = 8'h00;
        arm(5'd8);
        smp_period(8'h31, 4, 4, 1'b1, 0);
        smp_period(8'h32, 4, 4, 1'b1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({wr_en_o, wr_addr_o, wr_data_o, busy_o, triggered_o, done_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid got en=%b addr=%0d data=%h busy=%b trig=%b done=%b, want all 0",
                     wr_en_o, wr_addr_o, wr_data_o, busy_o, triggered_o, done_o);
        end
        smp_period(8'h11, 4, 4, 1'b0, 0);
        arm(5'd1);
        smp_period(8'hA5, 4, 4, 1'b1, 0);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || triggered_o !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_rearm got done=%b busy=%b trig=%b pending=%0d, want done=1 busy=0 trig=1 pending=0",
                     done_o, busy_o, triggered_o, sb.size());
        end
    endtask

    task automatic test_held_high();
        trig_mask_i = 8'h00;
        arm(5'd2);
        smp_period(8'h3C, 50, 4, 1'b1, 0);
        checks++;
        if (sb.size() != 0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL held_high got pending=%0d busy=%b done=%b, want pending=0 busy=1 done=0",
                     sb.size(), busy_o, done_o);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trigger();
        test_full_depth();
        test_abort();
        test_reset_mid();
        test_held_high();
        repeat (4) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got pending=%0d, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
